// File: rtl/clock_tick_recovery.sv
// clock_tick_recovery
// Brings a slow divider-generated square wave into the clk domain, emits
// single-cycle rise/fall enable ticks, measures the rise-to-rise period in
// clk cycles, and reports frequency lock and loss-of-clock timeout.
module clock_tick_recovery #(
    parameter int SYNC_STAGES = 2,     // synchronizer depth on slow_clk (min 2)
    parameter int CNT_W       = 16,    // period counter / period output width
    parameter int TOL         = 2,     // max |period - reference| counted as a match
    parameter int LOCK_COUNT  = 4,     // consecutive matches needed for lock
    parameter int TIMEOUT     = 1000   // clk cycles without a rise before clock loss
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             enable,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]     TOL_VAL     = (CNT_W + 1)'(TOL);
    localparam logic [MATCH_W-1:0] LOCK_VAL    = MATCH_W'(LOCK_COUNT);

    // Tracking states: IDLE waits for any rise, FIRST waits for the rise that
    // closes the first full period, TRACK counts matches, LOCKED holds lock.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   prev;

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W:0]         cnt_inc;
    logic [CNT_W-1:0]       measured;
    logic                   measured_sat;
    logic [CNT_W:0]         meas_ext;
    logic [CNT_W:0]         ref_ext;
    logic [CNT_W:0]         diff;
    logic                   in_tol;

    logic [1:0]             state, state_d;
    logic [CNT_W-1:0]       ref_period, ref_period_d;
    logic [MATCH_W-1:0]     match, match_d;
    logic [MATCH_W-1:0]     match_inc;
    logic [CNT_W-1:0]       period_d;
    logic                   period_valid_d;
    logic                   locked_d;
    logic                   timeout_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain; keeps running while disabled so re-enable never
    // sees a stale level and fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            prev   <= s;
        end
    end

    // Registered edge ticks, gated by enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= enable & s & ~prev;
            fall_tick <= enable & ~s & prev;
        end
    end

    // Rise-to-rise cycle counter; restarts on each rise tick, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || rise_tick) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Measured period is cnt+1 at the tick; an all-ones result means the
    // counter saturated and the value is not trustworthy for matching.
    assign cnt_inc      = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign measured     = cnt_inc[CNT_W] ? CNT_MAX : cnt_inc[CNT_W-1:0];
    assign measured_sat = (measured == CNT_MAX);

    // One extra bit so the subtraction can never wrap.
    assign meas_ext  = {1'b0, measured};
    assign ref_ext   = {1'b0, ref_period};
    assign diff      = (meas_ext >= ref_ext) ? (meas_ext - ref_ext) : (ref_ext - meas_ext);
    assign in_tol    = !measured_sat && (diff <= TOL_VAL);
    assign match_inc = match + MATCH_W'(1);

    // Next-state logic: enable low dominates, then a rise tick, then timeout.
    // A rise in the same cycle that cnt hits TIMEOUT is processed normally.
    always_comb begin
        state_d        = state;
        period_d       = period;
        period_valid_d = period_valid;
        locked_d       = locked;
        timeout_d      = timeout;
        ref_period_d   = ref_period;
        match_d        = match;

        if (!enable) begin
            state_d        = ST_IDLE;
            match_d        = '0;
            locked_d       = 1'b0;
            period_valid_d = 1'b0;
            timeout_d      = 1'b0;
        end else if (rise_tick) begin
            timeout_d = 1'b0;
            case (state)
                ST_IDLE: begin
                    state_d = ST_FIRST;
                end
                ST_FIRST: begin
                    period_d       = measured;
                    period_valid_d = 1'b1;
                    ref_period_d   = measured;
                    match_d        = '0;
                    state_d        = ST_TRACK;
                end
                ST_TRACK: begin
                    period_d = measured;
                    if (in_tol) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_VAL) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        ref_period_d = measured;
                        match_d      = '0;
                    end
                end
                ST_LOCKED: begin
                    // Reference is frozen while locked so slow drift within
                    // tolerance cannot walk it away from the lock point.
                    period_d = measured;
                    if (!in_tol) begin
                        locked_d     = 1'b0;
                        ref_period_d = measured;
                        match_d      = '0;
                        state_d      = ST_TRACK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state != ST_IDLE && cnt == TIMEOUT_VAL) begin
            // Clock loss: drop validity and lock but keep the last period.
            timeout_d      = 1'b1;
            locked_d       = 1'b0;
            period_valid_d = 1'b0;
            match_d        = '0;
            state_d        = ST_IDLE;
        end
    end

    // Tracking state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            ref_period   <= '0;
            match        <= '0;
        end else begin
            state        <= state_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            locked       <= locked_d;
            timeout      <= timeout_d;
            ref_period   <= ref_period_d;
            match        <= match_d;
        end
    end

endmodule
